// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the memory stage.
// Misses write back a dirty victim, refill the block one word per beat, then replay as a hit.
module data_cache_ctrl #(
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [31:0]       cpu_rdata,
    output logic              hit,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [1:0]        state_dbg
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;
    localparam int TAG_W = ADDR_W - 2 - OFFSET_BITS - INDEX_BITS;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_REFILL    = 2'd2;

    // Memory handshake: a beat is presented while mem_req=1 and its outputs hold
    // steady until the rising edge where mem_ready=1 completes it; mem_ready is
    // ignored in every other cycle.
    logic [1:0]             state;
    logic [OFFSET_BITS-1:0] cnt;
    logic [LINES-1:0]       valid;
    logic [LINES-1:0]       dirty;
    logic [TAG_W-1:0]       tag_store  [LINES];
    logic [31:0]            data_store [LINES*WORDS];
    logic [INDEX_BITS-1:0]  miss_index;
    logic [TAG_W-1:0]       miss_tag;
    logic [TAG_W-1:0]       victim_tag;

    logic [OFFSET_BITS-1:0] req_offset;
    logic [INDEX_BITS-1:0]  req_index;
    logic [TAG_W-1:0]       req_tag;
    logic                   req;
    logic                   accept_hit;
    logic                   miss_start;
    logic                   last_beat;
    logic                   unused_byte_bits;

    assign req_offset       = cpu_addr[OFFSET_BITS+1:2];
    assign req_index        = cpu_addr[OFFSET_BITS+INDEX_BITS+1:OFFSET_BITS+2];
    assign req_tag          = cpu_addr[ADDR_W-1:OFFSET_BITS+INDEX_BITS+2];
    assign unused_byte_bits = ^cpu_addr[1:0];

    assign req        = cpu_read | cpu_write;
    assign hit        = req & valid[req_index] & (tag_store[req_index] == req_tag);
    assign stall      = (req & ~hit) | (state != S_IDLE);
    assign cpu_rdata  = data_store[{req_index, req_offset}];
    assign accept_hit = (state == S_IDLE) & hit;
    assign miss_start = (state == S_IDLE) & req & ~hit;
    assign last_beat  = (cnt == {OFFSET_BITS{1'b1}});
    assign state_dbg  = state;

    // Beat outputs depend only on state, cnt and the latched miss context, so a
    // reset forces them to zero without waiting for a clock edge.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {victim_tag, miss_index, cnt, 2'b00};
                mem_wdata = data_store[{miss_index, cnt}];
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {miss_tag, miss_index, cnt, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= S_IDLE;
            cnt        <= '0;
            valid      <= '0;
            dirty      <= '0;
            miss_index <= '0;
            miss_tag   <= '0;
            victim_tag <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_hit) begin
                        hit_count <= hit_count + 32'd1;
                        if (cpu_write) dirty[req_index] <= 1'b1;
                    end else if (miss_start) begin
                        miss_count <= miss_count + 32'd1;
                        miss_index <= req_index;
                        miss_tag   <= req_tag;
                        victim_tag <= tag_store[req_index];
                        cnt        <= '0;
                        // The line is dropped now so a partial refill never looks valid.
                        valid[req_index] <= 1'b0;
                        dirty[req_index] <= 1'b0;
                        state <= (valid[req_index] & dirty[req_index]) ? S_WRITEBACK : S_REFILL;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ready) begin
                        cnt <= cnt + OFFSET_BITS'(1);
                        if (last_beat) state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ready) begin
                        cnt <= cnt + OFFSET_BITS'(1);
                        if (last_beat) begin
                            valid[miss_index] <= 1'b1;
                            dirty[miss_index] <= 1'b0;
                            state             <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (accept_hit && cpu_write) data_store[{req_index, req_offset}] <= cpu_wdata;
        if (state == S_REFILL && mem_ready) begin
            data_store[{miss_index, cnt}] <= mem_rdata;
            if (last_beat) tag_store[miss_index] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: directed steps then random LW/SW traffic, checked against a
// flat shadow memory and a per-line tag model, with a word-per-beat memory responder.
module tb_data_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        hit;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [1:0]  state_dbg;

    data_cache_ctrl dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_rdata  (cpu_rdata),
        .hit        (hit),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: which block each line holds, plus the CPU-visible memory contents.
    bit          mvalid [32];
    bit          mdirty [32];
    logic [22:0] mtag   [32];
    logic [31:0] exp_mem  [logic [31:0]];
    logic [31:0] main_mem [logic [31:0]];
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
    logic [64:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (main_mem.exists(a)) return main_mem[a];
        return init_word(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
            mtag[i]   = '0;
        end
        exp_hits   = '0;
        exp_misses = '0;
        exp_mem    = main_mem;
    endtask

    // One CPU access, held until stall drops. abort_beat >= 0 pulls reset while
    // that refill beat is presented and returns at once.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay, input int abort_beat,
                          output bit aborted);
        int          idx;
        logic [22:0] tg;
        logic [31:0] wa;
        logic [31:0] ba;
        logic [64:0] ent;
        bit          exp_hit;
        bit          done;
        int          nbeats;
        int          beats;
        int          refill_beats;
        int          wait_cnt;
        int          stall_cycles;

        aborted = 1'b0;
        wa      = {addr[31:2], 2'b00};
        idx     = int'((addr >> 4) & 32'h1F);
        tg      = 23'(addr >> 9);
        exp_hit = mvalid[idx] && (mtag[idx] == tg);
        exp_q.delete();
        nbeats = 0;
        if (!exp_hit) begin
            if (mvalid[idx] && mdirty[idx]) begin
                for (int k = 0; k < 4; k++) begin
                    ba = {mtag[idx], 5'(idx), 2'(k), 2'b00};
                    exp_q.push_back({1'b1, ba, shadow_rd(ba)});
                    nbeats++;
                end
            end
            for (int k = 0; k < 4; k++) begin
                ba = {tg, 5'(idx), 2'(k), 2'b00};
                exp_q.push_back({1'b0, ba, 32'h0});
                nbeats++;
            end
        end

        @(negedge clk);
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_read  = rd;
        cpu_write = wr;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        check("hit", 32'(hit), 32'(exp_hit));
        check("stall", 32'(stall), 32'(!exp_hit));
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
        check("mem_req_idle", 32'(mem_req), 32'h0);

        if (exp_hit) begin
            if (!wr) check("rdata_hit", cpu_rdata, shadow_rd(wa));
            @(posedge clk);
            exp_hits = exp_hits + 32'd1;
        end else begin
            exp_misses   = exp_misses + 32'd1;
            done         = 1'b0;
            beats        = 0;
            refill_beats = 0;
            wait_cnt     = 0;
            stall_cycles = 1;
            @(posedge clk);
            for (int cyc = 0; cyc < 300 && !done; cyc++) begin
                @(negedge clk);
                mem_ready = 1'b0;
                #1;
                if (!stall) begin
                    done = 1'b1;
                    check("hit_replay", 32'(hit), 32'h1);
                    if (!wr) check("rdata_replay", cpu_rdata, shadow_rd(wa));
                end else begin
                    stall_cycles++;
                    if (mem_req) begin
                        if (abort_beat >= 0 && !mem_we && refill_beats == abort_beat) begin
                            rst_b = 1'b0;
                            #1;
                            check("abort_mem_req", 32'(mem_req), 32'h0);
                            check("abort_mem_we", 32'(mem_we), 32'h0);
                            check("abort_mem_addr", mem_addr, 32'h0);
                            check("abort_hit_count", hit_count, 32'h0);
                            check("abort_miss_count", miss_count, 32'h0);
                            aborted = 1'b1;
                            return;
                        end
                        if (wait_cnt == delay) begin
                            if (exp_q.size() == 0) begin
                                check("beat_extra", 32'(beats + 1), 32'(nbeats));
                            end else begin
                                ent = exp_q.pop_front();
                                check("beat_we", 32'(mem_we), 32'(ent[64]));
                                check("beat_addr", mem_addr, ent[63:32]);
                                if (ent[64]) check("beat_wdata", mem_wdata, ent[31:0]);
                            end
                            mem_ready = 1'b1;
                            if (mem_we) main_mem[mem_addr] = mem_wdata;
                            else begin
                                mem_rdata = mem_rd(mem_addr);
                                refill_beats++;
                            end
                            wait_cnt = 0;
                            beats++;
                        end else begin
                            wait_cnt++;
                            mem_rdata = $urandom;
                        end
                    end
                end
            end
            check("miss_done", 32'(done), 32'h1);
            check("beat_count", 32'(beats), 32'(nbeats));
            check("stall_cycles", 32'(stall_cycles), 32'(1 + nbeats * (delay + 1)));
            @(posedge clk);
            exp_hits = exp_hits + 32'd1;
            mdirty[idx] = 1'b0;
        end

        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
        if (wr) begin
            exp_mem[wa] = wdata;
            mdirty[idx] = 1'b1;
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ab;
        int          op;
        logic [22:0] tsel;
        logic [31:0] a;

        rst_b     = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("rst_hit", 32'(hit), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_hit_count", hit_count, 32'h0);
        check("rst_miss_count", miss_count, 32'h0);

        // Cold miss with a slow memory, then hits on the refilled block.
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 2, -1, ab);
        access(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0, -1, ab);
        access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, -1, ab);
        // Conflict on the dirty line: write back, then refill.
        access(1'b1, 1'b0, 32'h0000_1040, 32'h0, 1, -1, ab);
        access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, -1, ab);
        // Read and write together behave as a store.
        access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, -1, ab);
        access(1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678, 0, -1, ab);
        access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, -1, ab);
        access(1'b1, 1'b0, 32'h0000_1080, 32'h0, 3, -1, ab);
        access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, -1, ab);

        // Reset in the middle of the third refill beat.
        access(1'b1, 1'b0, 32'h0000_2040, 32'h0, 1, 2, ab);
        check("abort_reached", 32'(ab), 32'h1);
        @(negedge clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        mem_ready = 1'b0;
        rst_b     = 1'b1;
        model_reset();
        #1;
        check("post_rst_stall", 32'(stall), 32'h0);
        check("post_rst_hit_count", hit_count, 32'h0);
        check("post_rst_miss_count", miss_count, 32'h0);
        // Same address misses again; memory answers every cycle.
        access(1'b1, 1'b0, 32'h0000_2040, 32'h0, 0, -1, ab);
        access(1'b1, 1'b0, 32'h0000_004C, 32'h0, 0, -1, ab);

        for (int n = 0; n < 200; n++) begin
            op = int'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: tsel = 23'h0;
                1: tsel = 23'h1;
                2: tsel = 23'h8;
                default: tsel = 23'h7F_FFFF;
            endcase
            a = {tsel, 5'($urandom_range(2, 6)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            access(op != 2, op >= 2, a, $urandom, int'($urandom_range(0, 3)), -1, ab);
        end

        @(negedge clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("final_stall", 32'(stall), 32'h0);
        check("final_hit_count", hit_count, exp_hits);
        check("final_miss_count", miss_count, exp_misses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
